add_rs_unit: RTL and testbench
==============================

Name: add_rs_unit

Overview:
- Adder-class reservation station (NUM_RS entries, CDB tags add_1..add_3) with a pipelined integer/branch-compare execution unit.
- Receives issued instructions with renamed operands and snoops the CDB for pending operands.
- Dispatches ready entries into the execution pipeline and requests the CDB to broadcast each result.
- Its broadcasts feed the reorder buffer's CDB inputs (cdb_id/cdb_data) and all other stations.

Parameters:
DATA_W, 64, operand/result width
TAG_W, 4, CDB tag width; tag 0 = notag
NUM_RS, 3, station entries
BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i
ADD_LAT, 2, pipeline stages from dispatch to result register inclusive (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  issue request this cycle
issue_op  in  2  00 add, 01 sub, 10 compare-equal (branch), 11 reserved (treated as add)
issue_vj  in  DATA_W  operand j value (valid when issue_qj==0)
issue_qj  in  TAG_W  producer tag of operand j, 0 = value ready
issue_vk  in  DATA_W  operand k value
issue_qk  in  TAG_W  producer tag of operand k
issue_ready  out  1  a free entry exists
issue_tag  out  TAG_W  tag to be allocated if issue_valid is accepted this cycle
cdb_id  in  TAG_W  CDB broadcast tag, 0 = idle
cdb_data  in  DATA_W  CDB broadcast value
cdb_req  out  1  result register holds a result awaiting broadcast
cdb_req_tag  out  TAG_W  tag of held result
cdb_req_data  out  DATA_W  held result
cdb_grant  in  1  bus carries this unit's result this cycle
flush  in  1  mispredict flush from ROB

Behaviour:
- Reset/flush (rst or flush high at an edge): all entries not busy, all pipeline valids 0, result register empty. After reset: cdb_req=0, cdb_req_tag=0, cdb_req_data=0, issue_ready=1, issue_tag=BASE_TAG. Flush outranks issue, dispatch and grant in the same cycle; the colliding issue is dropped.
- Allocation: issue accepted when issue_valid && issue_ready. Takes the lowest-index non-busy entry; issue_tag is combinational from pre-edge state. With no free entry, issue_ready=0 and issue_valid is ignored.
- Same-cycle CDB capture at issue: if issue_qj equals a non-zero cdb_id, the entry stores cdb_data with qj=0. Same rule applies to k.
- Snoop: each busy entry with q!=0 equal to a non-zero cdb_id stores cdb_data and clears q.
  - The result of a pending op whose own tag is on the bus is captured like any other.
- Dispatch: an entry is eligible when busy, qj==0, qk==0, and not yet dispatched.
  - Lowest-index eligible entry enters stage 1 at the edge, at most one per cycle, only if the pipeline is not stalled.
  - An entry issued with both operands ready is eligible in the cycle after its issue edge.
  - An entry that becomes ready via snoop is eligible in the cycle after the snoop edge.
  - The entry stays busy (tag reserved) until broadcast.
- Arithmetic: add/sub modulo 2^DATA_W (no flags). Compare yields 1 if vj==vk, else 0, zero-extended.
- Latency: dispatch edge D; the result register loads at edge D+ADD_LAT-1; cdb_req is high from the following cycle.
- Output handshake:
  - cdb_req, cdb_req_tag and cdb_req_data are held stable until a cycle with cdb_grant=1.
  - At that edge the result register empties (or loads the next result in the same edge) and the owning entry is freed.
  - cdb_grant while cdb_req=0 is ignored.
- Stall: if the result register is full and cdb_grant=0, every pipeline stage holds and no dispatch occurs. No result is ever dropped or duplicated.
- Freed entry's issue_ready/issue_tag are visible the cycle after grant; no same-edge reuse.
- Simultaneous issue, snoop, dispatch and grant on different entries all take effect in one edge.

Test Plan:
- rst for 2 cycles -> cdb_req=0, cdb_req_tag=0, cdb_req_data=0, issue_ready=1, issue_tag=1.
- issue add vj=5 vk=7 qj=qk=0 at edge E0 -> dispatch E1, cdb_req=1 after E2 with tag 1, data 12; cdb_grant=1 one cycle -> cdb_req=0 next cycle, issue_tag=1 again.
- issue sub vj=0 qk=4; after 3 cycles drive cdb_id=4 cdb_data=1 -> result 0xFFFF_FFFF_FFFF_FFFF tag 1. Also issue with qj=6 in the same cycle cdb_id=6 data=9 -> captured, no wait.
- issue 3 ops all with qj=5 -> issue_ready=0, 4th issue_valid ignored; cdb_id=5 data=2 -> tags 1,2,3 broadcast in order over 3 grants.
- two ready compare ops (10==10, 3==4), hold cdb_grant=0 for 5 cycles -> tag 1 data 1 held stable, pipeline frozen; then grants -> tag 1 data 1, then tag 2 data 0, no loss.
- entries busy plus a result pending, assert flush with issue_valid -> next cycle cdb_req=0, issue_ready=1, issue_tag=1; the dropped issue never broadcasts.

Source files
------------

// File: rtl/add_rs_unit_if.sv
// rtl/add_rs_unit_if.sv - issue, CDB snoop and CDB request bundle for the adder reservation station
interface add_rs_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
);
  logic              issue_valid;
  logic [1:0]        issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [TAG_W-1:0]  issue_qj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qk;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;
  logic [TAG_W-1:0]  cdb_id;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_req;
  logic [TAG_W-1:0]  cdb_req_tag;
  logic [DATA_W-1:0] cdb_req_data;
  logic              cdb_grant;

  // Issue stage, CDB bus and arbiter side
  modport master (
    output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
    output cdb_id, cdb_data, cdb_grant,
    input  issue_ready, issue_tag, cdb_req, cdb_req_tag, cdb_req_data
  );

  // Reservation station side
  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
    input  cdb_id, cdb_data, cdb_grant,
    output issue_ready, issue_tag, cdb_req, cdb_req_tag, cdb_req_data
  );
endinterface

// File: rtl/add_rs_unit.sv
// rtl/add_rs_unit.sv - adder-class reservation station with pipelined add/sub/compare unit
module add_rs_unit #(
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 4,
  parameter int NUM_RS   = 3,
  parameter int BASE_TAG = 1,
  parameter int ADD_LAT  = 2
) (
  input logic   clk,
  input logic   rst,
  input logic   flush,
  add_rs_if.slave bus
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  // Station entries
  logic [NUM_RS-1:0] busy_q, busy_d;
  logic [NUM_RS-1:0] disp_q, disp_d;
  logic [1:0]        op_q [NUM_RS];
  logic [1:0]        op_d [NUM_RS];
  logic [DATA_W-1:0] vj_q [NUM_RS];
  logic [DATA_W-1:0] vj_d [NUM_RS];
  logic [DATA_W-1:0] vk_q [NUM_RS];
  logic [DATA_W-1:0] vk_d [NUM_RS];
  logic [TAG_W-1:0]  qj_q [NUM_RS];
  logic [TAG_W-1:0]  qj_d [NUM_RS];
  logic [TAG_W-1:0]  qk_q [NUM_RS];
  logic [TAG_W-1:0]  qk_d [NUM_RS];

  // Execution pipeline; the last stage is the result register driving the CDB request
  logic [ADD_LAT-1:0] pv_q, pv_d;
  logic [IDX_W-1:0]   pidx_q  [ADD_LAT];
  logic [IDX_W-1:0]   pidx_d  [ADD_LAT];
  logic [DATA_W-1:0]  pdata_q [ADD_LAT];
  logic [DATA_W-1:0]  pdata_d [ADD_LAT];

  logic             free_found, elig_found;
  logic [IDX_W-1:0] free_idx, elig_idx;
  logic             res_valid, res_grant, stall, do_issue, do_disp;

  function automatic logic [DATA_W-1:0] alu(input logic [1:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      2'b01:   r = a - b;
      2'b10:   r = {{(DATA_W-1){1'b0}}, (a == b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign res_valid = pv_q[ADD_LAT-1];
  assign res_grant = res_valid & bus.cdb_grant;
  assign stall     = res_valid & ~bus.cdb_grant;
  assign do_issue  = bus.issue_valid & free_found;
  assign do_disp   = elig_found & ~stall;

  assign bus.issue_ready  = free_found;
  assign bus.issue_tag    = free_found ? (TAG_W'(BASE_TAG) + TAG_W'(free_idx)) : '0;
  assign bus.cdb_req      = res_valid;
  assign bus.cdb_req_tag  = res_valid ? (TAG_W'(BASE_TAG) + TAG_W'(pidx_q[ADD_LAT-1])) : '0;
  assign bus.cdb_req_data = res_valid ? pdata_q[ADD_LAT-1] : '0;

  // Lowest-index free entry for allocation and lowest-index ready entry for dispatch
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    elig_found = 1'b0;
    elig_idx   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy_q[i] && !disp_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        elig_found = 1'b1;
        elig_idx   = IDX_W'(i);
      end
    end
  end

  // Entry next state: snoop, dispatch mark, free on grant, allocate on issue
  always_comb begin
    busy_d = busy_q;
    disp_d = disp_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    for (int i = 0; i < NUM_RS; i++) begin
      if (busy_q[i] && qj_q[i] != '0 && qj_q[i] == bus.cdb_id) begin
        vj_d[i] = bus.cdb_data;
        qj_d[i] = '0;
      end
      if (busy_q[i] && qk_q[i] != '0 && qk_q[i] == bus.cdb_id) begin
        vk_d[i] = bus.cdb_data;
        qk_d[i] = '0;
      end
      if (do_disp && elig_idx == IDX_W'(i)) begin
        disp_d[i] = 1'b1;
      end
      // Tag stays reserved until its own result has left the bus
      if (res_grant && pidx_q[ADD_LAT-1] == IDX_W'(i)) begin
        busy_d[i] = 1'b0;
        disp_d[i] = 1'b0;
      end
      if (do_issue && free_idx == IDX_W'(i)) begin
        busy_d[i] = 1'b1;
        disp_d[i] = 1'b0;
        op_d[i]   = bus.issue_op;
        if (bus.issue_qj != '0 && bus.issue_qj == bus.cdb_id) begin
          vj_d[i] = bus.cdb_data;
          qj_d[i] = '0;
        end else begin
          vj_d[i] = bus.issue_vj;
          qj_d[i] = bus.issue_qj;
        end
        if (bus.issue_qk != '0 && bus.issue_qk == bus.cdb_id) begin
          vk_d[i] = bus.cdb_data;
          qk_d[i] = '0;
        end else begin
          vk_d[i] = bus.issue_vk;
          qk_d[i] = bus.issue_qk;
        end
      end
    end
  end

  // Pipeline advance; a full, ungranted result register freezes every stage
  always_comb begin
    pv_d    = pv_q;
    pidx_d  = pidx_q;
    pdata_d = pdata_q;
    if (!stall) begin
      pv_d[0]    = do_disp;
      pidx_d[0]  = elig_idx;
      pdata_d[0] = alu(op_q[elig_idx], vj_q[elig_idx], vk_q[elig_idx]);
      for (int s = 1; s < ADD_LAT; s++) begin
        pv_d[s]    = pv_q[s-1];
        pidx_d[s]  = pidx_q[s-1];
        pdata_d[s] = pdata_q[s-1];
      end
    end
  end

  // Control state; flush discards every entry and in-flight result
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q <= '0;
      disp_q <= '0;
      pv_q   <= '0;
    end else begin
      busy_q <= busy_d;
      disp_q <= disp_d;
      pv_q   <= pv_d;
    end
  end

  // Payload registers; meaningful only while the matching busy/valid bit is set
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    vj_q    <= vj_d;
    vk_q    <= vk_d;
    qj_q    <= qj_d;
    qk_q    <= qk_d;
    pidx_q  <= pidx_d;
    pdata_q <= pdata_d;
  end

endmodule

// File: tb/tb_add_rs_unit.sv
// tb/tb_add_rs_unit.sv - scoreboard bench for add_rs_unit
module tb_add_rs_unit;
  localparam int DW  = 64;
  localparam int TW  = 4;
  localparam int NRS = 3;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  add_rs_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  add_rs_unit #(.DATA_W(DW), .TAG_W(TW), .NUM_RS(NRS), .BASE_TAG(1), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  typedef struct {int tag; logic [1:0] op; logic [DW-1:0] vj; logic [DW-1:0] vk; int qj; int qk;} pend_t;
  typedef struct {int tag; logic [DW-1:0] data;} exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];
  int    bcast_log[$];
  bit    rsv [NRS+1];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op == 2'b01) return a - b;
    if (op == 2'b10) return (a == b) ? 64'd1 : 64'd0;
    return a + b;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int model_free();
    for (int t = 1; t <= NRS; t++) if (!rsv[t]) return t;
    return 0;
  endfunction

  // Apply a broadcast to waiting ops; fully known ops become expected results
  function automatic void resolve(input int cid, input logic [DW-1:0] cd);
    pend_t keep[$];
    pend_t p;
    exp_t  e;
    foreach (pend_q[i]) begin
      p = pend_q[i];
      if (cid != 0 && p.qj == cid) begin p.vj = cd; p.qj = 0; end
      if (cid != 0 && p.qk == cid) begin p.vk = cd; p.qk = 0; end
      if (p.qj == 0 && p.qk == 0) begin
        e.tag  = p.tag;
        e.data = ref_result(p.op, p.vj, p.vk);
        exp_q.push_back(e);
      end else begin
        keep.push_back(p);
      end
    end
    pend_q = keep;
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input logic [DW-1:0] vj, input int qj,
                       input logic [DW-1:0] vk, input int qk, input int cid, input logic [DW-1:0] cd,
                       input bit g, input bit fl);
    int    ft;
    pend_t p;
    ft = model_free();
    check("issue_ready", {63'd0, bus.issue_ready}, (ft != 0) ? 64'd1 : 64'd0);
    if (ft != 0) check("issue_tag", {60'd0, bus.issue_tag}, ft);
    bus.issue_valid = v;
    bus.issue_op    = op;
    bus.issue_vj    = vj;
    bus.issue_qj    = TW'(qj);
    bus.issue_vk    = vk;
    bus.issue_qk    = TW'(qk);
    bus.cdb_id      = TW'(cid);
    bus.cdb_data    = cd;
    bus.cdb_grant   = g;
    flush           = fl;
    if (!fl) begin
      if (v && ft != 0) begin
        p.tag = ft; p.op = op; p.vj = vj; p.vk = vk; p.qj = qj; p.qk = qk;
        rsv[ft] = 1'b1;
        pend_q.push_back(p);
      end
      resolve(cid, cd);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      pend_q.delete();
      exp_q.delete();
      for (int t = 0; t <= NRS; t++) rsv[t] = 1'b0;
    end
  endtask

  task automatic idle(input bit g);
    drive(0, 2'b00, '0, 0, '0, 0, 0, '0, g, 0);
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (bus.cdb_req !== 1'b1 && lat < 10) begin
      idle(0);
      lat++;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0 || bus.cdb_req === 1'b1) && n < max) begin
      drive(0, 2'b00, '0, 0, '0, 0, (pend_q.size() != 0) ? 4 + (n % 12) : 0, {$urandom, $urandom}, 1, 0);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size() + pend_q.size());
    end
  endtask

  // Monitor: hold stability while stalled, and scoreboard every granted broadcast
  bit             hold_prev = 1'b0;
  logic [TW-1:0]  prev_tag;
  logic [DW-1:0]  prev_data;
  int             midx;
  always @(negedge clk) begin
    if (hold_prev && bus.cdb_req === 1'b1) begin
      check("hold_tag", {60'd0, bus.cdb_req_tag}, {60'd0, prev_tag});
      check("hold_data", bus.cdb_req_data, prev_data);
    end
    if (bus.cdb_req === 1'b1 && bus.cdb_grant === 1'b1) begin
      midx = -1;
      foreach (exp_q[i]) if (midx < 0 && exp_q[i].tag == int'(bus.cdb_req_tag)) midx = i;
      checks++;
      if (midx < 0) begin
        errors++;
        $display("FAIL bcast_unexpected: got tag %0d data %0h, required no broadcast", bus.cdb_req_tag, bus.cdb_req_data);
      end else begin
        check("bcast_data", bus.cdb_req_data, exp_q[midx].data);
        rsv[exp_q[midx].tag] = 1'b0;
        exp_q.delete(midx);
      end
      bcast_log.push_back(int'(bus.cdb_req_tag));
    end
    hold_prev = (bus.cdb_req === 1'b1) && (bus.cdb_grant !== 1'b1);
    prev_tag  = bus.cdb_req_tag;
    prev_data = bus.cdb_req_data;
  end

  initial begin
    int lat;
    logic [DW-1:0] a, b;
    bus.issue_valid = 0; bus.issue_op = 0; bus.issue_vj = 0; bus.issue_qj = 0;
    bus.issue_vk = 0; bus.issue_qk = 0; bus.cdb_id = 0; bus.cdb_data = 0; bus.cdb_grant = 0;
    flush = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_req", {63'd0, bus.cdb_req}, 0);
    check("rst_req_tag", {60'd0, bus.cdb_req_tag}, 0);
    check("rst_req_data", bus.cdb_req_data, 0);
    check("rst_ready", {63'd0, bus.issue_ready}, 1);
    check("rst_tag", {60'd0, bus.issue_tag}, 1);

    // add 5+7, ready operands
    drive(1, 2'b00, 64'd5, 0, 64'd7, 0, 0, '0, 0, 0);
    wait_req(lat);
    check("lat_add", lat, LAT);
    idle(1);
    check("req_after_grant", {63'd0, bus.cdb_req}, 0);
    check("tag_after_grant", {60'd0, bus.issue_tag}, 1);

    // sub waiting on tag 4, then same-cycle capture of tag 6
    drive(1, 2'b01, 64'd0, 0, '0, 4, 0, '0, 0, 0);
    repeat (3) idle(0);
    check("sub_waits", {63'd0, bus.cdb_req}, 0);
    drive(0, 2'b00, '0, 0, '0, 0, 4, 64'd1, 0, 0);
    drain(20);
    drive(1, 2'b00, '0, 6, 64'd1, 0, 6, 64'd9, 0, 0);
    wait_req(lat);
    check("lat_capture", lat, LAT);
    drain(20);

    // fill the station, extra issue ignored, release in tag order
    for (int i = 0; i < 3; i++) drive(1, 2'b00, '0, 5, 64'(i), 0, 0, '0, 0, 0);
    check("full_ready", {63'd0, bus.issue_ready}, 0);
    drive(1, 2'b00, 64'd99, 0, 64'd1, 0, 0, '0, 0, 0);
    bcast_log.delete();
    drive(0, 2'b00, '0, 0, '0, 0, 5, 64'd2, 1, 0);
    drain(30);
    check("order_cnt", bcast_log.size(), 3);
    for (int i = 0; i < bcast_log.size() && i < 3; i++) check("order_tag", bcast_log[i], i + 1);

    // compares under a 5-cycle stall
    bcast_log.delete();
    drive(1, 2'b10, 64'd10, 0, 64'd10, 0, 0, '0, 0, 0);
    drive(1, 2'b10, 64'd3, 0, 64'd4, 0, 0, '0, 0, 0);
    wait_req(lat);
    repeat (5) idle(0);
    check("stall_tag", {60'd0, bus.cdb_req_tag}, 1);
    check("stall_data", bus.cdb_req_data, 1);
    drain(20);
    check("cmp_cnt", bcast_log.size(), 2);
    if (bcast_log.size() == 2) check("cmp_second", bcast_log[1], 2);

    // flush with busy entries and a pending result
    drive(1, 2'b00, 64'd1, 0, 64'd1, 0, 0, '0, 0, 0);
    drive(1, 2'b00, '0, 7, 64'd1, 0, 0, '0, 0, 0);
    drive(1, 2'b01, 64'd8, 0, 64'd3, 0, 0, '0, 0, 0);
    repeat (3) idle(0);
    check("pre_flush_req", {63'd0, bus.cdb_req}, 1);
    drive(1, 2'b00, 64'd4, 0, 64'd4, 0, 0, '0, 0, 1);
    flush = 0;
    check("flush_req", {63'd0, bus.cdb_req}, 0);
    check("flush_ready", {63'd0, bus.issue_ready}, 1);
    check("flush_tag", {60'd0, bus.issue_tag}, 1);
    repeat (10) drive(0, 2'b00, '0, 0, '0, 0, 7, 64'd5, 1, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      a = {$urandom, $urandom};
      b = ($urandom % 4 == 0) ? a : {$urandom, $urandom};
      if ($urandom % 250 == 0) begin
        drive(1, 2'($urandom), a, 0, b, 0, 0, '0, 0, 1);
        flush = 0;
      end else begin
        drive($urandom % 3 != 0, 2'($urandom), a, ($urandom % 2) ? 0 : 4 + $urandom % 12,
              b, ($urandom % 2) ? 0 : 4 + $urandom % 12,
              ($urandom % 3 == 0) ? 4 + $urandom % 12 : 0, {$urandom, $urandom},
              $urandom % 4 != 0, 0);
      end
    end
    drain(500);
    check("final_outstanding", exp_q.size() + pend_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
